// File: rtl/player_pkg.sv
// Shared encodings for the playback sequencer and its beat divider.
// Holds FSM state codes, speed codes, and song length/index width.
package player_pkg;

  localparam int LEN     = 4095;
  localparam int IBEAT_W = 12;

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LOOP  = 2'd3;

  localparam logic [1:0] SPD_X1 = 2'd0;
  localparam logic [1:0] SPD_X2 = 2'd1;
  localparam logic [1:0] SPD_X4 = 2'd2;

endpackage

// File: rtl/playback_sequencer_beat_divider.sv
// Tempo divider: counts clk cycles, registers a one-cycle beat strobe.
// Ports: clk, rst, en, clr, speed in; fire (comb, wrap this cycle), strobe out.
module beat_divider
  import player_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       fire,
  output logic       strobe
);

  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] tc;
  logic          strobe_q;

  always_comb begin
    case (speed)
      SPD_X2:  tc = CW'((TICK_DIV >> 1) - 1);
      SPD_X4:  tc = CW'((TICK_DIV >> 2) - 1);
      default: tc = CW'(TICK_DIV - 1);
    endcase
  end

  // A clear wins over the wrap, so no strobe escapes a stop or speed change.
  assign fire = en & ~clr & (cnt_q == tc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || fire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= fire;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/playback_sequencer.sv
// Button-driven STOP/PLAY/PAUSE/LOOP sequencer for the note player.
// Ports: clk, rst, btn_* pulses, ibeat in; play_pause, loop_de,
// loop_width, reverse, rewind, speed, state out (all registered).
// Option: AUTO_REPEAT_EN keeps PLAY running at end of song.
module playback_sequencer
#(
  parameter int TICK_DIV = 25_000_000,
  parameter int LEN      = player_pkg::LEN,
  parameter int IBEAT_W  = player_pkg::IBEAT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_play,
  input  logic               btn_stop,
  input  logic               btn_loop,
  input  logic               btn_rev,
  input  logic               btn_width,
  input  logic               btn_speed,
  input  logic [IBEAT_W-1:0] ibeat,
  output logic               play_pause,
  output logic               loop_de,
  output logic [2:0]         loop_width,
  output logic               reverse,
  output logic               rewind,
  output logic [1:0]         speed,
  output logic [1:0]         state
);

  import player_pkg::*;

  logic [1:0] state_q, state_d;
  logic [2:0] width_q, width_d;
  logic [1:0] speed_q, speed_d;
  logic       rev_q, rev_d;
  logic       pend_q, pend_d;
  logic       rewind_q, rewind_d;
  logic       loop_q;

  logic stop_c, play_c, loop_c;
  logic rev_c, wid_c, spd_c;
  logic running, fire, rev_eff;

  // Only the highest-priority pulse survives.
  assign stop_c = btn_stop;
  assign play_c = btn_play & ~btn_stop;
  assign loop_c = btn_loop & ~btn_play & ~btn_stop;
  assign rev_c  = btn_rev & ~btn_loop
                & ~btn_play & ~btn_stop;
  assign wid_c  = btn_width & ~btn_rev & ~btn_loop
                & ~btn_play & ~btn_stop;
  assign spd_c  = btn_speed & ~btn_width & ~btn_rev
                & ~btn_loop & ~btn_play & ~btn_stop;

  assign running = (state_q == ST_PLAY)
                 | (state_q == ST_LOOP);

  beat_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (running),
    .clr    (stop_c | spd_c),
    .speed  (speed_q),
    .fire   (fire),
    .strobe (play_pause)
  );

  // Direction the player will use for the beat now being issued.
  assign rev_eff = rev_q ^ pend_q;

`ifndef AUTO_REPEAT_EN
  logic eos;
  assign eos = fire & (state_q == ST_PLAY)
             & (rev_eff ? (ibeat == '0)
                        : (ibeat == IBEAT_W'(LEN - 1)));
`endif

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    speed_d  = speed_q;
    rev_d    = rev_q;
    pend_d   = pend_q;
    rewind_d = 1'b0;

    // Pending direction commits with the strobe it rides on.
    if (fire) begin
      rev_d  = rev_eff;
      pend_d = 1'b0;
    end

    unique case (1'b1)
      stop_c: begin
        state_d  = ST_STOP;
        rewind_d = 1'b1;
        pend_d   = 1'b0;
      end
      play_c: begin
        case (state_q)
          ST_STOP:  state_d = ST_PLAY;
          ST_PLAY:  state_d = ST_PAUSE;
          ST_PAUSE: state_d = ST_PLAY;
          default:  state_d = state_q;
        endcase
      end
      loop_c: begin
        if (state_q == ST_PLAY) begin
          state_d = ST_LOOP;
        end else if (state_q == ST_LOOP) begin
          state_d = ST_PLAY;
        end
      end
      rev_c: begin
        if (running) begin
          pend_d = ~pend_d;
        end else begin
          rev_d = ~rev_q;
        end
      end
      wid_c: begin
        width_d = (width_q == 3'd4) ? 3'd1
                : width_q + 3'd1;
      end
      spd_c: begin
        speed_d = (speed_q == SPD_X4) ? SPD_X1
                : speed_q + 2'd1;
      end
      default: ;
    endcase

`ifndef AUTO_REPEAT_EN
    if (eos) begin
      state_d  = ST_STOP;
      rewind_d = 1'b1;
      rev_d    = 1'b0;
      pend_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STOP;
      width_q  <= 3'd1;
      speed_q  <= SPD_X1;
      rev_q    <= 1'b0;
      pend_q   <= 1'b0;
      rewind_q <= 1'b0;
      loop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      speed_q  <= speed_d;
      rev_q    <= rev_d;
      pend_q   <= pend_d;
      rewind_q <= rewind_d;
      loop_q   <= (state_d == ST_LOOP);
    end
  end

  assign state      = state_q;
  assign loop_width = width_q;
  assign speed      = speed_q;
  assign reverse    = rev_q;
  assign rewind     = rewind_q;
  assign loop_de    = loop_q;

endmodule

// File: tb/tb_playback_sequencer.sv
// Directed bench for playback_sequencer at TICK_DIV=8.
// Honours AUTO_REPEAT_EN for the end-of-song expectation.
module tb_playback_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_play = 1'b0;
  logic        btn_stop = 1'b0;
  logic        btn_loop = 1'b0;
  logic        btn_rev = 1'b0;
  logic        btn_width = 1'b0;
  logic        btn_speed = 1'b0;
  logic [11:0] ibeat = 12'd100;
  logic        play_pause;
  logic        loop_de;
  logic [2:0]  loop_width;
  logic        reverse;
  logic        rewind;
  logic [1:0]  speed;
  logic [1:0]  state;

  int n_run = 0;
  int n_fail = 0;

  playback_sequencer #(
    .TICK_DIV (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_play   (btn_play),
    .btn_stop   (btn_stop),
    .btn_loop   (btn_loop),
    .btn_rev    (btn_rev),
    .btn_width  (btn_width),
    .btn_speed  (btn_speed),
    .ibeat      (ibeat),
    .play_pause (play_pause),
    .loop_de    (loop_de),
    .loop_width (loop_width),
    .reverse    (reverse),
    .rewind     (rewind),
    .speed      (speed),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // b = {stop, play, loop, rev, width, speed}
  task automatic press(input logic [5:0] b);
    {btn_stop, btn_play, btn_loop,
     btn_rev, btn_width, btn_speed} = b;
    tick();
    {btn_stop, btn_play, btn_loop,
     btn_rev, btn_width, btn_speed} = 6'b0;
  endtask

  task automatic wait_pp(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (play_pause) begin
        n = i;
        break;
      end
    end
  endtask

  localparam logic [5:0] B_STOP  = 6'b100000;
  localparam logic [5:0] B_PLAY  = 6'b010000;
  localparam logic [5:0] B_LOOP  = 6'b001000;
  localparam logic [5:0] B_REV   = 6'b000100;
  localparam logic [5:0] B_WIDTH = 6'b000010;
  localparam logic [5:0] B_SPEED = 6'b000001;

  initial begin : main
    int n;
    int cnt;
    int early;

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_state", int'(state), 0);
    chk("rst_pp", int'(play_pause), 0);
    chk("rst_width", int'(loop_width), 1);
    chk("rst_rev", int'(reverse), 0);
    chk("rst_rewind", int'(rewind), 0);
    chk("rst_speed", int'(speed), 0);
    chk("rst_loopde", int'(loop_de), 0);

    // reverse toggles at once while stopped
    press(B_REV);
    chk("stop_rev_on", int'(reverse), 1);
    press(B_REV);
    chk("stop_rev_off", int'(reverse), 0);

    press(B_PLAY);
    chk("play_state", int'(state), 1);
    wait_pp(n);
    chk("first_beat", n, 8);
    tick();
    chk("pp_one_cycle", int'(play_pause), 0);
    wait_pp(n);
    chk("period_x1", n + 1, 8);

    // pause with counter at 5, hold 20 cycles
    for (int i = 0; i < 4; i++) tick();
    press(B_PLAY);
    chk("pause_state", int'(state), 2);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (play_pause) cnt++;
    end
    chk("pause_no_pp", cnt, 0);
    press(B_LOOP);
    chk("pause_loop_ign", int'(state), 2);
    press(B_PLAY);
    chk("resume_state", int'(state), 1);
    wait_pp(n);
    chk("resume_beat", n, 3);

    // deferred direction change
    for (int i = 0; i < 3; i++) tick();
    press(B_REV);
    chk("rev_held", int'(reverse), 0);
    early = 0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (play_pause) begin
        n = i;
        break;
      end
      if (reverse) early = 1;
    end
    chk("rev_beat", n, 4);
    chk("rev_early", early, 0);
    chk("rev_on_strobe", int'(reverse), 1);

    tick();
    tick();
    press(B_REV);
    tick();
    press(B_REV);
    wait_pp(n);
    chk("rev2_beat", n, 3);
    chk("rev_twice", int'(reverse), 1);
    press(B_REV);
    wait_pp(n);
    chk("rev_back", int'(reverse), 0);

    press(B_LOOP);
    chk("loop_state", int'(state), 3);
    chk("loop_de_on", int'(loop_de), 1);
    press(B_STOP | B_PLAY | B_LOOP);
    chk("combo_state", int'(state), 0);
    chk("combo_rewind", int'(rewind), 1);
    chk("combo_loopde", int'(loop_de), 0);
    tick();
    chk("rewind_pulse", int'(rewind), 0);

    // end of song, forward
    ibeat = 12'd4094;
    press(B_PLAY);
    wait_pp(n);
    chk("eos_beat", n, 8);
`ifdef AUTO_REPEAT_EN
    chk("eos_state", int'(state), 1);
    chk("eos_rewind", int'(rewind), 0);
    ibeat = 12'd100;
    press(B_STOP);
`else
    chk("eos_state", int'(state), 0);
    chk("eos_rewind", int'(rewind), 1);
    ibeat = 12'd100;
    tick();
    chk("eos_rw_off", int'(rewind), 0);
`endif

    // speed stepping
    press(B_PLAY);
    wait_pp(n);
    chk("spd0_beat", n, 8);
    tick();
    tick();
    press(B_SPEED);
    chk("speed1", int'(speed), 1);
    wait_pp(n);
    chk("spd1_first", n, 4);
    wait_pp(n);
    chk("spd1_period", n, 4);
    press(B_SPEED);
    chk("speed2", int'(speed), 2);
    wait_pp(n);
    chk("spd2_first", n, 2);
    wait_pp(n);
    chk("spd2_period", n, 2);
    press(B_SPEED);
    chk("speed0", int'(speed), 0);
    wait_pp(n);
    chk("spd0_again", n, 8);

    press(B_WIDTH);
    chk("width2", int'(loop_width), 2);
    press(B_WIDTH);
    chk("width3", int'(loop_width), 3);
    press(B_WIDTH);
    chk("width4", int'(loop_width), 4);
    press(B_WIDTH);
    chk("width_wrap", int'(loop_width), 1);

    // loop beats width in the same cycle
    press(B_LOOP | B_WIDTH);
    chk("prio_state", int'(state), 3);
    chk("prio_width", int'(loop_width), 1);
    press(B_LOOP);
    chk("unloop", int'(state), 1);

    // async reset mid-beat
    press(B_SPEED);
    press(B_WIDTH);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("mrst_state", int'(state), 0);
    chk("mrst_speed", int'(speed), 0);
    chk("mrst_width", int'(loop_width), 1);
    chk("mrst_pp", int'(play_pause), 0);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (play_pause) cnt++;
    end
    chk("mrst_no_pp", cnt, 0);
    chk("mrst_stop", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/playback_sequencer.md
Name: playback_sequencer

Overview:
- Sequences the note-index player that advances one beat per cycle while its play_pause input is high.
- Turns one-pulse button commands into a STOP/PLAY/PAUSE/LOOP state machine.
- Generates the tempo beat strobe and drives the player's play_pause, loop_de, loop_width and reverse controls.
- Sits between the button one-pulse/debounce logic and the player. All three run on the same clk.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per beat at speed 0.
- LEN, 4095: song length in beats. Must match the player's LEN.
- IBEAT_W, 12: width of the beat index.

Ports:
- clk  in  1  system clock
- rst  in  1  reset (asynchronous, active-high)
- btn_play  in  1  one-cycle pulse; toggles PLAY/PAUSE, or starts from STOP
- btn_stop  in  1  one-cycle pulse; go to STOP and rewind
- btn_loop  in  1  one-cycle pulse; toggles LOOP
- btn_rev  in  1  one-cycle pulse; toggles direction
- btn_width  in  1  one-cycle pulse; cycles loop width 1→2→3→4→1
- btn_speed  in  1  one-cycle pulse; cycles speed 0→1→2→0
- ibeat  in  IBEAT_W  current beat index from the player
- play_pause  out  1  one-cycle beat strobe to the player
- loop_de  out  1  high when state == LOOP
- loop_width  out  3  loop width, 1..4
- reverse  out  1  committed direction; 1 = backward
- rewind  out  1  one-cycle pulse; player reset request
- speed  out  2  tempo level
- state  out  2  STOP=0, PLAY=1, PAUSE=2, LOOP=3

Behaviour:
- Reset values: state=STOP, play_pause=0, loop_de=0, loop_width=1, reverse=0, rewind=0, speed=0. Divider counter=0, rev_pending=0.
- Divider terminal count:
  - TC = (TICK_DIV >> speed) - 1, so speed 1 halves the beat period and speed 2 quarters it.
  - The counter increments only in PLAY or LOOP.
  - At TC the counter wraps to 0, and play_pause is registered high for exactly the next cycle.
- Counter hold/clear rules:
  - PAUSE holds the counter value.
  - Entering STOP clears it.
  - A speed change clears it in the same cycle, so the first beat after the change arrives a full new period later.
- FSM transitions:
  - STOP --btn_play--> PLAY.
  - PLAY --btn_play--> PAUSE.
  - PAUSE --btn_play--> PLAY.
  - PLAY --btn_loop--> LOOP.
  - LOOP --btn_loop--> PLAY.
  - PAUSE --btn_loop--> no effect.
  - Any state --btn_stop--> STOP, with rewind=1 for one cycle.
- Simultaneous button priority: stop > play > loop > rev > width > speed. Only the highest-priority pulse in a cycle is acted on; the others are dropped.
- Direction change:
  - btn_rev sets rev_pending (a second btn_rev clears it).
  - reverse toggles, and rev_pending clears, on the cycle the beat strobe fires.
  - Result: a direction change never splits a beat.
  - In STOP or PAUSE, reverse toggles immediately.
- Width change: btn_width takes effect immediately; loop_width wraps 4→1.
- End of song:
  - Condition: in PLAY, a strobe fires with ibeat==LEN-1 and reverse=0, or ibeat==0 and reverse=1.
  - Result: next state is STOP, rewind pulses on the same cycle as the strobe, and reverse clears.
  - LOOP ignores end-of-song, because the player bounds it.
- Latency:
  - Button pulse to state change: 1 cycle.
  - Terminal count to play_pause: 1 cycle, registered.
  - All outputs are registered.
- rst asserted mid-beat: all registers return to reset values immediately; no strobe is issued.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: the end-of-song condition in PLAY does not stop. State stays PLAY, no rewind is issued, and the player's own wrap-around continues the song.
- Undefined: end-of-song behaves as described under Behaviour.

Decomposition:
- Shared package (player_pkg):
  - state encodings ST_STOP/ST_PLAY/ST_PAUSE/ST_LOOP.
  - LEN and IBEAT_W.
  - speed encodings SPD_X1/SPD_X2/SPD_X4.
- One sub-module, beat_divider: counter plus terminal-count compare.
  - Inputs: enable, clear, speed.
  - Output: registered strobe.
  - The FSM and command logic stay in playback_sequencer.

Test Plan:
- TICK_DIV=8, reset, btn_play: state 0→1 after 1 cycle; play_pause pulses every 8 cycles; first pulse 8–9 cycles after entering PLAY.
- PLAY, btn_play after 5 counts, wait 20 cycles, btn_play: no strobes during PAUSE; next strobe 3 counts after resume.
- PLAY, btn_rev mid-beat: reverse stays 0 until the next strobe and flips on that exact strobe cycle. btn_rev twice within a beat: reverse unchanged.
- Same-cycle btn_stop+btn_play+btn_loop from LOOP: state→STOP, rewind=1 one cycle, loop_de=0.
- ibeat driven to 4094 in PLAY forward, strobe fires:
  - Without AUTO_REPEAT_EN: state→STOP and rewind pulses.
  - With AUTO_REPEAT_EN: state stays PLAY, no rewind.
- btn_speed in PLAY with TICK_DIV=8: strobe period 8→4→2→8; counter clears on each change; btn_width ×4 returns loop_width to 1.
